monitor_contador: RTL and testbench

- Downstream consumer of the 16-bit counter's outputs Q[15:0] and RCO[3:0].
- Extends the count to 32 bits by tracking full-word wraps (RCO[3]) in a 16-bit "vueltas" register.
- On request, captures {vueltas, Q} snapshots into a small first-word-fall-through (FWFT) FIFO.
- Snapshots drain to a sink through a valid/ready handshake; adds overflow and wrap-error flags.

---
 rtl/monitor_contador.sv | 96 +++++++++
 tb/tb_monitor_contador.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/monitor_contador.sv
// monitor_contador: watches a 16-bit counter (Q, RCO), extends its count
// to 32 bits with a wrap register and queues {vueltas, Q} snapshots in a
// small first-word-fall-through FIFO. A valid/ready handshake drains the FIFO.
module monitor_contador #(
  parameter int ANCHO = 16,
  parameter int PROF  = 4,
  parameter int PTR   = 2
) (
  input  logic                 clk,
  input  logic                 reset_L,
  input  logic                 enb,
  input  logic [1:0]           modo,
  input  logic [ANCHO-1:0]     Q,
  input  logic [3:0]           RCO,
  input  logic                 captura,
  input  logic                 listo,
  output logic                 valido,
  output logic [2*ANCHO-1:0]   dato_out,
  output logic [ANCHO-1:0]     vueltas,
  output logic [PTR:0]         ocupacion,
  output logic                 vacio,
  output logic                 lleno,
  output logic                 desborde,
  output logic                 err_vueltas
);

  localparam logic [ANCHO-1:0] V_UNO   = {{(ANCHO-1){1'b0}}, 1'b1};
  localparam logic [ANCHO-1:0] V_UNOS  = {ANCHO{1'b1}};
  localparam logic [ANCHO-1:0] V_CERO  = {ANCHO{1'b0}};
  localparam logic [PTR:0]     O_UNO   = {{PTR{1'b0}}, 1'b1};
  localparam logic [PTR:0]     O_LLENO = (PTR+1)'(PROF);
  localparam logic [PTR-1:0]   P_UNO   = {{(PTR-1){1'b0}}, 1'b1};

  logic [2*ANCHO-1:0] mem [PROF];
  logic [PTR-1:0]     wr_ptr;
  logic [PTR-1:0]     rd_ptr;
  logic               push;
  logic               pop;

  // Status flags all come from the occupancy count; a full FIFO still
  // accepts a capture when the head is leaving on the same edge.
  always_comb begin
    vacio    = (ocupacion == {(PTR+1){1'b0}});
    lleno    = (ocupacion == O_LLENO);
    valido   = !vacio;
    pop      = valido && listo;
    push     = captura && (!lleno || pop);
    dato_out = mem[rd_ptr];
  end

  // Wrap counter: follows the counter's full-word carry/borrow, cleared by load.
  always_ff @(posedge clk) begin
    if (!reset_L) begin
      vueltas     <= V_CERO;
      err_vueltas <= 1'b0;
    end else if (enb) begin
      if (modo == 2'b11) begin
        vueltas <= V_CERO;
      end else if (RCO[3]) begin
        if (modo == 2'b00) begin
          vueltas <= vueltas + V_UNO;
          if (vueltas == V_UNOS) err_vueltas <= 1'b1;
        end else begin
          vueltas <= vueltas - V_UNO;
          if (vueltas == V_CERO) err_vueltas <= 1'b1;
        end
      end
    end
  end

  // FIFO control: pointers, occupancy and the sticky overflow flag.
  always_ff @(posedge clk) begin
    if (!reset_L) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      ocupacion <= '0;
      desborde  <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + P_UNO;
      if (pop)  rd_ptr <= rd_ptr + P_UNO;
      if (push && !pop)      ocupacion <= ocupacion + O_UNO;
      else if (pop && !push) ocupacion <= ocupacion - O_UNO;
      if (captura && !push) desborde <= 1'b1;
    end
  end

  // FIFO storage: snapshot pairs the wrap count before this edge with Q now.
  always_ff @(posedge clk) begin
    if (!reset_L) begin
      for (int i = 0; i < PROF; i++) mem[i] <= '0;
    end else if (push) begin
      mem[wr_ptr] <= {vueltas, Q};
    end
  end

endmodule

// File: tb/tb_monitor_contador.sv
// Directed self-checking bench for monitor_contador.
module tb_monitor_contador;

  logic        clk = 1'b0;
  logic        reset_L;
  logic        enb;
  logic [1:0]  modo;
  logic [15:0] Q;
  logic [3:0]  RCO;
  logic        captura;
  logic        listo;
  logic        valido;
  logic [31:0] dato_out;
  logic [15:0] vueltas;
  logic [2:0]  ocupacion;
  logic        vacio;
  logic        lleno;
  logic        desborde;
  logic        err_vueltas;

  int checks   = 0;
  int failures = 0;

  monitor_contador #(.ANCHO(16), .PROF(4), .PTR(2)) dut (
    .clk(clk), .reset_L(reset_L), .enb(enb), .modo(modo), .Q(Q), .RCO(RCO),
    .captura(captura), .listo(listo), .valido(valido), .dato_out(dato_out),
    .vueltas(vueltas), .ocupacion(ocupacion), .vacio(vacio), .lleno(lleno),
    .desborde(desborde), .err_vueltas(err_vueltas)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Directed sequence following the test plan.
  initial begin
    reset_L = 1'b0; enb = 1'b0; modo = 2'b00; Q = 16'd0; RCO = 4'd0;
    captura = 1'bx; listo = 1'bx;
    #2;

    // 1: reset, then count up with three carries
    tick(); tick();
    check("rst_vueltas", 32'(vueltas), 32'd0);
    check("rst_ocup",    32'(ocupacion), 32'd0);
    check("rst_vacio",   32'(vacio), 32'd1);
    check("rst_lleno",   32'(lleno), 32'd0);
    check("rst_valido",  32'(valido), 32'd0);
    check("rst_desb",    32'(desborde), 32'd0);
    check("rst_err",     32'(err_vueltas), 32'd0);
    check("rst_dato",    dato_out, 32'd0);
    reset_L = 1'b1; captura = 1'b0; listo = 1'b0; enb = 1'b1; modo = 2'b00;
    for (int i = 0; i < 6; i++) begin
      Q   = 16'(i);
      RCO = (i % 2 == 0) ? 4'b1000 : 4'b0000;
      tick();
    end
    RCO = 4'd0;
    check("t1_vueltas", 32'(vueltas), 32'd3);
    check("t1_err",     32'(err_vueltas), 32'd0);
    check("t1_vacio",   32'(vacio), 32'd1);
    check("t1_valido",  32'(valido), 32'd0);

    // 2: load clears, borrow from zero wraps and flags error
    modo = 2'b11; RCO = 4'b1000; tick();
    check("t2_load", 32'(vueltas), 32'd0);
    modo = 2'b01; RCO = 4'b1000; tick();
    RCO = 4'd0;
    check("t2_borrow", 32'(vueltas), 32'h0000FFFF);
    check("t2_err",    32'(err_vueltas), 32'd1);

    // 3: capture three snapshots with vueltas=5, then drain
    modo = 2'b11; tick();
    modo = 2'b00; RCO = 4'b1000;
    for (int i = 0; i < 5; i++) tick();
    RCO = 4'd0; enb = 1'b0;
    check("t3_v5", 32'(vueltas), 32'd5);
    listo = 1'b0; captura = 1'b1; Q = 16'd10; tick();
    check("t3_valido", 32'(valido), 32'd1);
    check("t3_head0",  dato_out, {16'd5, 16'd10});
    Q = 16'd20; tick();
    Q = 16'd30; tick();
    captura = 1'b0;
    check("t3_ocup", 32'(ocupacion), 32'd3);
    check("t3_hold", dato_out, {16'd5, 16'd10});
    listo = 1'b1; tick();
    check("t3_head1", dato_out, {16'd5, 16'd20});
    tick();
    check("t3_head2", dato_out, {16'd5, 16'd30});
    tick();
    check("t3_vacio", 32'(vacio), 32'd1);

    // 4: overflow drops the fifth capture
    listo = 1'b0; captura = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      Q = 16'(i); tick();
      if (i == 4) begin
        check("t4_lleno", 32'(lleno), 32'd1);
        check("t4_desb0", 32'(desborde), 32'd0);
      end
    end
    captura = 1'b0;
    check("t4_desb1", 32'(desborde), 32'd1);
    check("t4_ocup",  32'(ocupacion), 32'd4);
    listo = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      check("t4_drain", dato_out, {16'd5, 16'(i)});
      tick();
    end
    check("t4_vacio", 32'(vacio), 32'd1);

    // 5: simultaneous push and pop on a full FIFO
    reset_L = 1'b0; tick(); reset_L = 1'b1;
    listo = 1'b0; captura = 1'b1;
    for (int i = 1; i <= 4; i++) begin Q = 16'(i); tick(); end
    check("t5_full", 32'(lleno), 32'd1);
    listo = 1'b1; Q = 16'd9; tick();
    captura = 1'b0;
    check("t5_ocup", 32'(ocupacion), 32'd4);
    check("t5_desb", 32'(desborde), 32'd0);
    check("t5_d0", dato_out, {16'd0, 16'd2}); tick();
    check("t5_d1", dato_out, {16'd0, 16'd3}); tick();
    check("t5_d2", dato_out, {16'd0, 16'd4}); tick();
    check("t5_d3", dato_out, {16'd0, 16'd9}); tick();
    check("t5_vacio", 32'(vacio), 32'd1);

    // 6: enable gating, then reset discards queued entries
    listo = 1'b0; enb = 1'b1; modo = 2'b00; RCO = 4'b1000;
    tick(); tick();
    check("t6_v2", 32'(vueltas), 32'd2);
    enb = 1'b0;
    for (int i = 0; i < 4; i++) begin modo = 2'(i); tick(); end
    RCO = 4'd0;
    check("t6_hold", 32'(vueltas), 32'd2);
    captura = 1'b1;
    for (int i = 0; i < 7; i++) begin Q = 16'(100 + i); tick(); end
    captura = 1'b0;
    check("t6_desb_set", 32'(desborde), 32'd1);
    reset_L = 1'b0; captura = 1'bx; listo = 1'bx; tick();
    check("t6_ocup", 32'(ocupacion), 32'd0);
    check("t6_vueltas", 32'(vueltas), 32'd0);
    check("t6_desb", 32'(desborde), 32'd0);
    check("t6_valido", 32'(valido), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
